// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//  - state_t    : controller FSM encoding (IDLE/LOW/HIGH/DONE, 2 bits)
//  - op_t       : latched access type (OP_RD / OP_WR)
//  - BASE_ADDR_DEF : CPU byte address that maps to SRAM half-word 0
//  - word_index : CPU byte address -> 32-bit word index relative to the base
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int unsigned BASE_ADDR_DEF = 1024;

  // Byte address bits [1:0] are dropped by the shift; the caller truncates
  // the result to the SRAM word-index width, so out-of-range addresses wrap.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// wait_counter: 4-bit wait-state counter for one half-word phase.
// Ports:
//  clk   in   clock
//  rst   in   synchronous active-high reset (cnt -> 0)
//  clr   in   synchronous clear (priority over en)
//  en    in   count enable
//  cnt   out  current count
//  term  out  1 when cnt == WAIT_CYC (last cycle of the phase)
module wait_counter #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt,
  output logic       term
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign term = (cnt == 4'(WAIT_CYC));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: sequences 32-bit MEM-stage loads/stores onto a 16-bit
// asynchronous SRAM as two half-word phases (LOW then HIGH), each lasting
// WAIT_CYC+1 cycles. ready=0 freezes the pipeline until the DONE cycle.
// Ports:
//  clk, rst              clock, synchronous active-high reset
//  rd_en, wr_en          load / store request from EXE/MEM (both = store)
//  address, wdata        CPU byte address and store data
//  rdata                 load data, valid in the DONE cycle of a load
//  ready                 1 = MEM stage may advance
//  sram_addr             SRAM half-word address
//  sram_dq_out/_oe/_in   SRAM data pad: write data, output enable, read data
//  sram_we_n             SRAM write strobe, active-low
module mem_stage_sram_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYC  = 1,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n
);

  state_t            state_q, state_d;
  op_t               op_q;
  logic [ADDR_W-2:0] idx_q, idx_d;
  logic [31:0]       wdata_q;
  logic [3:0]        cnt;
  logic              term;
  logic              cnt_clr, cnt_en;
  logic              req;
  logic              in_phase;
  logic              is_wr;

  assign req   = rd_en | wr_en;
  assign idx_d = (ADDR_W-1)'(word_index(address, 32'(BASE_ADDR)));

  wait_counter #(.WAIT_CYC(WAIT_CYC)) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .term (term)
  );

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: if (req) state_d = LOW;
      LOW: begin
        cnt_clr = term;
        cnt_en  = ~term;
        if (term) state_d = HIGH;
      end
      HIGH: begin
        cnt_clr = term;
        cnt_en  = ~term;
        if (term) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the latched request copy has no reset; every output it feeds is
  // gated by state, which is reset, so its power-up value is never visible.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      op_q    <= wr_en ? OP_WR : OP_RD;
      idx_q   <= idx_d;
      wdata_q <= wdata;
    end
  end

  // Each half of rdata is captured on the last (hold) cycle of its phase and
  // then kept until the next load overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (op_q == OP_RD && term) begin
      if (state_q == LOW)  rdata[15:0]  <= sram_dq_in;
      if (state_q == HIGH) rdata[31:16] <= sram_dq_in;
    end
  end

  // SRAM side is decoded only from registered state so the pads never see
  // glitches from the pipeline inputs.
  assign in_phase    = (state_q == LOW) || (state_q == HIGH);
  assign is_wr       = (op_q == OP_WR);
  assign sram_addr   = in_phase ? {idx_q, (state_q == HIGH)} : '0;
  assign sram_dq_oe  = in_phase && is_wr;
  assign sram_dq_out = !sram_dq_oe      ? 16'd0 :
                       (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  // The last cycle of a write phase keeps address/data valid with the strobe
  // released, giving the asynchronous SRAM its hold time.
  assign sram_we_n   = ~(sram_dq_oe && !term);

  assign ready = (state_q == IDLE && !req) || (state_q == DONE);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Testbench for mem_stage_sram_ctrl. Two instances: i0 with WAIT_CYC=1 and
// i1 with WAIT_CYC=2. The driver pushes the expected transaction into a
// per-instance scoreboard queue; a per-instance monitor checks the SRAM-side
// outputs every cycle against the phase timing and pops/compares on DONE.
module tb_mem_stage_sram_ctrl;

  typedef struct {
    bit          wr;
    logic [16:0] idx;
    logic [31:0] wdata;
    logic [31:0] rdata_exp;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        rd_en       [2];
  logic        wr_en       [2];
  logic [31:0] address     [2];
  logic [31:0] wdata       [2];
  logic [31:0] rdata       [2];
  logic        ready       [2];
  logic [17:0] sram_addr   [2];
  logic [15:0] sram_dq_out [2];
  logic        sram_dq_oe  [2];
  logic [15:0] sram_dq_in  [2];
  logic        sram_we_n   [2];

  logic [15:0] sram_mem [8];
  txn_t        sb_q [2][$];
  int          done_cyc [2];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int WC = (g == 0) ? 1 : 2;

    mem_stage_sram_ctrl #(.WAIT_CYC(WC), .ADDR_W(18), .BASE_ADDR(1024)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en[g]),
      .wr_en       (wr_en[g]),
      .address     (address[g]),
      .wdata       (wdata[g]),
      .rdata       (rdata[g]),
      .ready       (ready[g]),
      .sram_addr   (sram_addr[g]),
      .sram_dq_out (sram_dq_out[g]),
      .sram_dq_oe  (sram_dq_oe[g]),
      .sram_dq_in  (sram_dq_in[g]),
      .sram_we_n   (sram_we_n[g])
    );

    assign sram_dq_in[g] = sram_mem[sram_addr[g][2:0]];

    int   k = 0;
    txn_t t;

    // k = cycles since the request was first seen in IDLE.
    always @(negedge clk) begin
      if (rst) begin
        k = 0;
      end else if (rd_en[g] | wr_en[g]) begin
        check($sformatf("i%0d_sb_nonempty", g), 32'(sb_q[g].size() > 0), 32'd1);
        if (sb_q[g].size() > 0) begin
          t = sb_q[g][0];
          if (!ready[g]) begin
            bit          lo, hi;
            int          c;
            logic [17:0] exp_addr;
            lo = (k >= 1) && (k <= WC + 1);
            hi = (k >= WC + 2) && (k <= 2 * WC + 2);
            c  = lo ? k - 1 : k - WC - 2;
            exp_addr = lo ? {t.idx, 1'b0} : hi ? {t.idx, 1'b1} : 18'd0;
            check($sformatf("i%0d_inflight_k%0d", g, k), 32'(k <= 2 * WC + 2), 32'd1);
            check($sformatf("i%0d_addr_k%0d", g, k), 32'(sram_addr[g]), 32'(exp_addr));
            check($sformatf("i%0d_oe_k%0d", g, k), 32'(sram_dq_oe[g]), 32'(t.wr && (lo || hi)));
            check($sformatf("i%0d_we_n_k%0d", g, k), 32'(sram_we_n[g]),
                  32'(!(t.wr && (lo || hi) && c < WC)));
            if (t.wr && (lo || hi))
              check($sformatf("i%0d_dq_out_k%0d", g, k), 32'(sram_dq_out[g]),
                    32'(lo ? t.wdata[15:0] : t.wdata[31:16]));
            k++;
          end else begin
            check($sformatf("i%0d_latency", g), 32'(k), 32'(2 * WC + 3));
            check($sformatf("i%0d_rdata_done", g), rdata[g], t.rdata_exp);
            check($sformatf("i%0d_done_we_n", g), 32'(sram_we_n[g]), 32'd1);
            check($sformatf("i%0d_done_oe", g), 32'(sram_dq_oe[g]), 32'd0);
            void'(sb_q[g].pop_front());
            done_cyc[g] = cyc;
            k = 0;
          end
        end
      end else begin
        k = 0;
        check($sformatf("i%0d_idle_ready", g), 32'(ready[g]), 32'd1);
        check($sformatf("i%0d_idle_we_n", g), 32'(sram_we_n[g]), 32'd1);
        check($sformatf("i%0d_idle_oe", g), 32'(sram_dq_oe[g]), 32'd0);
        check($sformatf("i%0d_idle_addr", g), 32'(sram_addr[g]), 32'd0);
      end
    end
  end

  // Call right after a rising edge (+#1); the request is seen in that cycle.
  task automatic start(input int g, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [16:0] idx, input logic [31:0] rexp);
    txn_t t;
    t.wr = wr; t.idx = idx; t.wdata = d; t.rdata_exp = rexp;
    sb_q[g].push_back(t);
    rd_en[g] = rd; wr_en[g] = wr; address[g] = a; wdata[g] = d;
  endtask

  // Waits (bounded) for the DONE cycle, then steps past its rising edge.
  task automatic wait_done(input int g, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready[g]) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("i%0d_%s_handshake", g, name), 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int g);
    rd_en[g] = 1'b0; wr_en[g] = 1'b0;
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 8; i++) sram_mem[i] = 16'h0000;
    sram_mem[0] = 16'hBEEF; sram_mem[1] = 16'hDEAD;
    sram_mem[4] = 16'h1111; sram_mem[5] = 16'h2222;
    for (int g = 0; g < 2; g++) begin
      rd_en[g] = 1'b0; wr_en[g] = 1'b0; address[g] = 32'd0; wdata[g] = 32'd0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("i%0d_rst_ready", g), 32'(ready[g]), 32'd1);
      check($sformatf("i%0d_rst_rdata", g), rdata[g], 32'd0);
      check($sformatf("i%0d_rst_dq_out", g), 32'(sram_dq_out[g]), 32'd0);
    end

    // Load @1024: half-words 0,1 -> 0xDEADBEEF.
    @(posedge clk); #1;
    start(0, 1'b1, 1'b0, 32'd1024, 32'd0, 17'd0, 32'hDEADBEEF);
    wait_done(0, "load");
    idle(0);

    // Store @1032: half-words 4,5; rdata keeps the previous load value.
    @(posedge clk); #1;
    start(0, 1'b0, 1'b1, 32'd1032, 32'h12345678, 17'd2, 32'hDEADBEEF);
    wait_done(0, "store");
    idle(0);

    // Ten idle cycles; the monitor checks the idle outputs each cycle.
    repeat (10) @(posedge clk);

    // rd_en and wr_en together: executed as a store, rdata unchanged.
    #1;
    start(0, 1'b1, 1'b1, 32'd1024, 32'hA5A55A5A, 17'd0, 32'hDEADBEEF);
    wait_done(0, "dual");
    idle(0);

    // Reset in cycle 2 of a store @1040 aborts it with no DONE.
    @(posedge clk); #1;
    start(0, 1'b0, 1'b1, 32'd1040, 32'hFFFF0000, 17'd4, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(0);
    sb_q[0].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("i0_abort_we_n", 32'(sram_we_n[0]), 32'd1);
    check("i0_abort_oe", 32'(sram_dq_oe[0]), 32'd0);
    check("i0_abort_rdata_cleared", rdata[0], 32'd0);

    // W=2 back-to-back load @1032 then store @1036: second DONE 15 cycles in.
    @(posedge clk); #1;
    start(1, 1'b1, 1'b0, 32'd1032, 32'd0, 17'd2, 32'h22221111);
    t0 = cyc;
    wait_done(1, "b2b_load");
    start(1, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 17'd3, 32'h22221111);
    wait_done(1, "b2b_store");
    idle(1);
    check("i1_b2b_total_cycles", 32'(done_cyc[1] - t0), 32'd15);

    repeat (4) @(posedge clk);
    check("i0_sb_drained", 32'(sb_q[0].size()), 32'd0);
    check("i1_sb_drained", 32'(sb_q[1].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
